// File: rtl/bit_ser_pkg.sv
// Shared definitions for the bit serializer: state encoding, GAP counter
// width and the level driven on x while no word bit is presented.
package bit_ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int   GAP_CNT_W = 4;
   localparam logic X_IDLE    = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the serial pattern detector. Words are
// accepted over valid/ready and shifted out MSB-first, one bit per clock,
// with no bubble between back-to-back words when GAP is 0.
// Optional feature: define BIT_SER_PARITY_EN to append one even-parity bit
// after each word; word_done and the next-word handshake then move to the
// parity cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a word, x held at idle level, in_ready high
// ST_SHIFT | presenting data bits MSB-first, counter tracks bits left
// ST_PAR   | presenting the even-parity bit (parity build only)
// ST_GAP   | forced idle cycles after a word, no word accepted
module bit_serializer
   import bit_ser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int                   CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
   localparam logic                 NO_GAP   = (GAP == 0);

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [GAP_CNT_W-1:0]   gcnt_q, gcnt_d;
   logic                   x_d, x_valid_d;
   logic                   final_bit;
   logic                   accept;
`ifdef BIT_SER_PARITY_EN
   logic                   par_q, par_d;
`endif

   // Final bit of a word: last data bit, or the parity bit when it exists.
   always_comb begin
`ifdef BIT_SER_PARITY_EN
      final_bit = (state_q == ST_PAR);
`else
      final_bit = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif
   end

   assign in_ready  = (state_q == ST_IDLE) || (final_bit && NO_GAP);
   assign accept    = in_valid && in_ready;
   assign word_done = final_bit;
   assign busy      = (state_q != ST_IDLE);

   // Next state, datapath updates and next-cycle serial outputs.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
`ifdef BIT_SER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            shreg_d = shreg_q << 1;
            if (cnt_q == '0) begin
`ifdef BIT_SER_PARITY_EN
               state_d = ST_PAR;
`else
               state_d = NO_GAP ? ST_IDLE : ST_GAP;
               gcnt_d  = GAP_LOAD;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef BIT_SER_PARITY_EN
         ST_PAR: begin
            state_d = NO_GAP ? ST_IDLE : ST_GAP;
            gcnt_d  = GAP_LOAD;
         end
`endif
         ST_GAP: begin
            if (gcnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A handshake only happens in IDLE or on a gapless final bit, so it
      // always starts a fresh word regardless of the exit chosen above.
      if (accept) begin
         state_d = ST_SHIFT;
         shreg_d = in_data;
         cnt_d   = CNT_LOAD;
`ifdef BIT_SER_PARITY_EN
         par_d   = ^in_data;
`endif
      end

      x_valid_d = (state_d == ST_SHIFT);
      x_d       = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : X_IDLE;
`ifdef BIT_SER_PARITY_EN
      if (state_d == ST_PAR) begin
         x_valid_d = 1'b1;
         x_d       = par_d;
      end
`endif
   end

   // State, datapath and registered serial outputs; reset aborts any word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         x       <= X_IDLE;
         x_valid <= 1'b0;
`ifdef BIT_SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         x       <= x_d;
         x_valid <= x_valid_d;
`ifdef BIT_SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: two instances (GAP=0 and GAP=2) share
// clock and reset. The driver pushes each accepted word's expected bit stream
// into a per-instance queue; the monitor pops one bit per valid cycle and
// derives in_ready, word_done, busy and idle levels from the queue state.
module tb_bit_serializer;

   localparam int W = 8;
   localparam int GAPS [2] = '{0, 2};

   typedef struct {
      logic [W-1:0] data;
      int           delay;
   } item_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] din  [2];
   logic         dval [2];
   logic         rdy  [2];
   logic         xo   [2];
   logic         xv   [2];
   logic         done [2];
   logic         bsy  [2];

   bit    exp_q    [2][$];
   item_t stim     [2][$];
   int    gap_left [2];
   bit    hold     [2];
   bit    hs_pend  [2];
   int    wait_cnt [2];

   int n_checks = 0;
   int n_fail   = 0;

   bit_serializer #(.WIDTH(W), .GAP(GAPS[0])) dut0 (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(dval[0]),
      .in_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]),
      .word_done(done[0]), .busy(bsy[0])
   );

   bit_serializer #(.WIDTH(W), .GAP(GAPS[1])) dut1 (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(dval[1]),
      .in_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]),
      .word_done(done[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int d, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t actual=%b expected=%b", name, d, $time, act, exp);
      end
   endtask

   // Expected serial stream of one word: MSB first, then optional even parity.
   task automatic push_word(input int d, input logic [W-1:0] data);
      for (int i = W - 1; i >= 0; i--) exp_q[d].push_back(data[i]);
`ifdef BIT_SER_PARITY_EN
      exp_q[d].push_back(^data);
`endif
   endtask

   // Monitor: compare every output against the queue-based model each cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic e_v, e_x, e_done, e_rdy, e_busy;
         if (exp_q[d].size() > 0) begin
            e_v = 1'b1; e_x = exp_q[d][0]; e_done = (exp_q[d].size() == 1);
            e_rdy = (exp_q[d].size() == 1) && (GAPS[d] == 0); e_busy = 1'b1;
         end else if (gap_left[d] > 0) begin
            e_v = 1'b0; e_x = 1'b0; e_done = 1'b0; e_rdy = 1'b0; e_busy = 1'b1;
         end else begin
            e_v = 1'b0; e_x = 1'b0; e_done = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
         end
         check("x_valid", d, xv[d], e_v);
         check("x", d, xo[d], e_x);
         check("word_done", d, done[d], e_done);
         check("in_ready", d, rdy[d], e_rdy);
         check("busy", d, bsy[d], e_busy);
         if (exp_q[d].size() > 0) begin
            void'(exp_q[d].pop_front());
            if (exp_q[d].size() == 0 && GAPS[d] > 0) gap_left[d] = GAPS[d];
         end else if (gap_left[d] > 0) begin
            gap_left[d]--;
         end
      end
   end

   // One driver step, run just after each falling edge.
   task automatic drive_step();
      for (int d = 0; d < 2; d++) begin
         if (hs_pend[d]) begin
            hold[d] = 1'b0; dval[d] = 1'b0; wait_cnt[d] = 0;
         end
         if (!hold[d] && stim[d].size() > 0) begin
            if (wait_cnt[d] < stim[d][0].delay) begin
               wait_cnt[d]++;
            end else begin
               item_t it;
               it = stim[d].pop_front();
               din[d] = it.data; dval[d] = 1'b1; hold[d] = 1'b1; wait_cnt[d] = 0;
            end
         end
         hs_pend[d] = dval[d] && rdy[d];
         if (hs_pend[d]) push_word(d, din[d]);
      end
   endtask

   function automatic bit all_idle();
      for (int d = 0; d < 2; d++)
         if (stim[d].size() > 0 || hold[d] || hs_pend[d] || exp_q[d].size() > 0 || gap_left[d] > 0)
            return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_stim(input int max_cycles);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk); #1;
         drive_step();
         cyc++;
      end while (!all_idle() && cyc < max_cycles);
      n_checks++;
      if (!all_idle()) begin
         n_fail++;
         $display("FAIL drain_timeout t=%0t cycles=%0d expected_idle=1", $time, cyc);
      end
   endtask

   task automatic async_idle_check(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_x"}, d, xo[d], 1'b0);
         check({tag, "_x_valid"}, d, xv[d], 1'b0);
         check({tag, "_busy"}, d, bsy[d], 1'b0);
         check({tag, "_word_done"}, d, done[d], 1'b0);
         check({tag, "_in_ready"}, d, rdy[d], 1'b1);
      end
   endtask

   initial begin
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         din[d] = '0; dval[d] = 1'b0; gap_left[d] = 0;
         hold[d] = 1'b0; hs_pend[d] = 1'b0; wait_cnt[d] = 0;
      end
      #1;
      async_idle_check("reset");
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;

      // Directed words, then randomized words with mostly back-to-back timing.
      for (int d = 0; d < 2; d++) begin
         stim[d].push_back('{8'hB0, 0});
         stim[d].push_back('{8'h0B, 14});
         stim[d].push_back('{8'hB0, 0});
         stim[d].push_back('{8'hAA, 3});
         stim[d].push_back('{8'h03, 0});
         stim[d].push_back('{8'hFF, 0});
         for (int i = 0; i < 60; i++) begin
            int dl;
            dl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            stim[d].push_back('{W'($urandom), dl});
         end
      end
      run_stim(4000);

      // Reset in the middle of an all-ones word, after its third bit.
      for (int d = 0; d < 2; d++) stim[d].push_back('{8'hFF, 0});
      @(negedge clk); #1;
      drive_step();
      @(negedge clk); #1;
      drive_step();
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_q[d].delete(); gap_left[d] = 0;
         dval[d] = 1'b0; hold[d] = 1'b0; hs_pend[d] = 1'b0; wait_cnt[d] = 0;
      end
      #1;
      async_idle_check("midword_reset");
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);

      // Clean restart after the aborted word.
      for (int d = 0; d < 2; d++) begin
         stim[d].push_back('{8'h5A, 0});
         stim[d].push_back('{8'hC3, 0});
      end
      run_stim(200);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stage sitting directly upstream of the serial pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a single-bit stream that drives the detector's serial input. Back-to-back words stream with no bubble, so patterns that span a word boundary remain detectable downstream. Idle cycles present a constant 0.

## Interface
- WIDTH, 8: word width in bits; minimum 2.
- GAP, 0: forced idle cycles inserted after each word; range 0..15.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to serialize; sampled on handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the detector; registered.
- x_valid  output  1  x carries a word bit (data or parity) this cycle.
- word_done  output  1  one-cycle pulse coinciding with the final bit of a word.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, PAR (present only with the macro), GAP.
- Handshake occurs on a rising edge when in_valid && in_ready. in_data is captured into the shift register, and the bit counter is loaded with WIDTH-1.
- IDLE: in_ready=1, x=0, x_valid=0. On handshake, go to SHIFT.
- SHIFT: x = shreg[WIDTH-1], x_valid=1. Shift left each cycle and decrement the counter.
  - Last data bit is counter==0.
  - From the last data bit: go to PAR if enabled; else to GAP if GAP>0; else to SHIFT if a handshake occurs this cycle; else to IDLE.
- PAR: x = even parity of the captured word (^word), x_valid=1. Next state follows the same rules as the SHIFT last-bit exit.
- GAP: x=0, x_valid=0, in_ready=0. Counts GAP cycles, then goes to IDLE.
- in_ready = IDLE || (final bit cycle && GAP==0). The final bit cycle is the last SHIFT bit, or PAR when the macro is enabled.
- word_done=1 during the final bit cycle only.
- in_data/in_valid are ignored when in_ready=0. The upstream source must hold them until accepted.
- Counter width: $clog2(WIDTH). The GAP counter is 4 bits. No wrap beyond the loaded value.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1, x=0, x_valid=0, word_done=0, busy=0, shift register cleared.
- Reset mid-word aborts the word immediately. No partial word or parity bit resumes after release.
- Latency: the word MSB appears on x in the cycle after the handshake edge.
- A word occupies WIDTH cycles, or WIDTH+1 with parity, plus GAP idle cycles.
- Throughput at GAP=0: 100%, with a continuous x_valid across consecutive words.
- Handshake on the final-bit cycle: the next word's MSB follows the previous final bit on the very next cycle.
- in_valid deasserted on the final-bit cycle: IDLE next cycle, x=0.

## Configuration
- BIT_SER_PARITY_EN defined: each word is followed by one even-parity bit in state PAR. word_done and in_ready move to the parity cycle.
- BIT_SER_PARITY_EN undefined: PAR state and parity logic are absent. A word is exactly WIDTH bits.

## Structure
- Shared package bit_ser_pkg holds:
  - the state enum (IDLE, SHIFT, PAR, GAP);
  - the GAP counter width constant (4);
  - the idle-level constant for x (1'b0).
- Single module. Shift register, counters and parity XOR are inline; no sub-module is warranted.

## Test plan
- Single word, WIDTH=8, GAP=0: send 8'hB0 -> x = 1,0,1,1,0,0,0,0 on cycles 1–8 after the handshake. x_valid high for those 8 cycles, word_done on cycle 8, then x=0, x_valid=0, in_ready=1.
- Back-to-back: send 8'h0B then 8'hB0 with in_valid held -> second handshake on cycle 8. 16 contiguous valid bits 0000_1011_1011_0000, with no x_valid gap.
- GAP=2: two words back-to-back -> after the first word's 8th bit, 2 cycles of x=0, x_valid=0, in_ready=0. Then 1 IDLE cycle with in_ready=1, handshake, and the second word starts.
- BIT_SER_PARITY_EN, send 8'hB0 -> 9th bit is 1 (three ones). word_done on bit 9. Send 8'h03 -> 9th bit is 0.
- Reset mid-word: drop rst after bit 3 of 8'hFF -> x=0, x_valid=0, busy=0 asynchronously. After release, in_ready=1 and no residual bits appear.
- Backpressure: assert in_valid with 8'hAA during SHIFT of a prior word (not on the final bit) -> not accepted until the final-bit cycle. The word is then sent exactly once.
